mul_hilo_ctrl: RTL and testbench
================================

# mul_hilo_ctrl

Execute-stage controller for the HI/LO register pair. It decodes multiply-class and HI/LO move ops, issues operands to the 4-stage pipelined 32x32 multiplier core and stalls the EX stage while a product is pending. When the core signals ready, it writes the 64-bit result into HI/LO, or accumulates it into HI/LO. It sits directly upstream of the multiplier core (drives start/sign/A/B) and consumes that core's result and ready outputs.

## Interface
- (no parameters)
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- op_valid  in  1  EX-stage instruction valid
- op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 MFHI, 4 MFLO, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; others NOP
- rs_data  in  32  first source operand
- rt_data  in  32  second source operand
- flush  in  1  exception/redirect kill of EX instruction
- stall_o  out  1  EX must hold its instruction
- hilo_rdata  out  32  HI for MFHI, LO for MFLO, else 0
- hi_o, lo_o  out  32 each  architectural HI/LO
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_sign  out  1  1 = signed multiply
- mul_a, mul_b  out  32 each  multiplier operands (registered)
- mul_result  in  64  product from the multiplier
- mul_ready  in  1  product valid (one-cycle pulse)

## Operation
- Mult-class ops: MULT, MULTU, plus MADD/MADDU/MSUB/MSUBU when enabled (see Configuration). Signed variants are MULT, MADD and MSUB.
- States:
  - IDLE: on op_valid & mult-class & !flush, latch rs/rt into mul_a/mul_b, latch sign and accumulate mode (none/add/sub), then go to START.
  - START: mul_start=1 for exactly this cycle, then go to WAIT.
  - WAIT: hold until mul_ready=1. At that edge write HI/LO, then go to DONE.
  - DONE: stall_o=0 for one cycle, so the held instruction retires. op is ignored. Go to IDLE.
- HI/LO write:
  - plain: {HI,LO} <= mul_result
  - add: {HI,LO} <= {HI,LO} + mul_result
  - sub: {HI,LO} <= {HI,LO} − mul_result
  - all arithmetic 64-bit, wraps mod 2^64
- MTHI/MTLO: write rs_data at the edge when IDLE & op_valid & !flush. No stall.
- MFHI/MFLO: hilo_rdata is combinational from the current HI/LO. Valid in IDLE/DONE, no stall.
- stall_o = (IDLE & op_valid & mult-class & !flush) | START | WAIT.
- flush in any state: next state IDLE, no HI/LO write, latched op dropped, mul_start forced 0 that cycle.
- mul_ready is consumed only in WAIT. A stale pulse from a flushed op arriving in IDLE/START/DONE is ignored. Any later start reloads the core, so no stale ready can reach a new WAIT.
- Reset: state IDLE. HI, LO, mul_a, mul_b, mul_sign, mul_start, stall_o, hilo_rdata all 0.

## Timing
- Cycle 0: mult-class op seen in IDLE, stall_o=1.
- Cycle 1: START, mul_start=1.
- Cycles 2–4: WAIT.
- Cycle 5: mul_ready=1; HI/LO written at the end of this cycle.
- Cycle 6: DONE. New HI/LO visible, stall_o=0, instruction advances.
- Totals: stall_o high for 6 cycles; next instruction enters in cycle 7.
- mul_a/mul_b/mul_sign stay stable from START through WAIT.
- An MFHI/MFLO following a mult reads the updated value with no further stall.
- Simultaneous flush and mul_ready in WAIT: flush wins, no write.

## Configuration
- MUL_ACC_EN defined: ops 7–10 are mult-class and accumulate/subtract into HI/LO as above.
- MUL_ACC_EN undefined:
  - ops 7–10 decode as NOP: no stall, no write, no mul_start
  - accumulate datapath (64-bit adder/subtractor) is not built

## Test plan
- Reset asserted 2 cycles -> hi_o=lo_o=0, stall_o=0, mul_start=0, hilo_rdata=0.
- MULT rs=0xFFFFFFFE, rt=0x00000003 with the real multiplier core attached -> mul_start pulses in cycle 1 with mul_sign=1, stall_o high cycles 0–5, cycle 6 hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
- MULTU rs=rt=0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001, mul_sign=0.
- MTHI 0x12345678, MTLO 0x9ABCDEF0, then MULT with flush in cycle 3 -> HI/LO unchanged, stall_o=0 next cycle. The following MFLO gives hilo_rdata=0x9ABCDEF0.
- MADDU with HI=0, LO=0xFFFFFFFF, rs=rt=1 -> hi_o=0x00000001, lo_o=0x00000000. MSUB with HI=LO=0, rs=2, rt=3 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA. With MUL_ACC_EN undefined, the same ops give no stall and HI/LO unchanged.
- Back-to-back MULT then MFHI -> MFHI is presented in cycle 7, hilo_rdata equals the new HI, no extra stall.

Source files
------------

// File: rtl/mul_hilo_ctrl.sv
// EX-stage HI/LO controller: decodes mult-class and HI/LO move ops, drives the 4-stage multiplier core, stalls EX until the product lands.
// Optional: define MUL_ACC_EN to build MADD/MADDU/MSUB/MSUBU and the 64-bit accumulate datapath.
module mul_hilo_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        stall_o,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mul_start,
  output logic        mul_sign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  input  logic        mul_ready
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MFHI  = 4'd3;
  localparam logic [3:0] OP_MFLO  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MUL_ACC_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;
  acc_t acc_d, acc_q;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;
  state_t state_q;

  logic        is_mult, is_sgn;
  logic        start_q, sign_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic [63:0] hilo_d;

  always_comb begin
    is_mult = 1'b0;
    is_sgn  = 1'b0;
`ifdef MUL_ACC_EN
    acc_d   = ACC_NONE;
`endif
    case (op)
      OP_MULT:  begin is_mult = 1'b1; is_sgn = 1'b1; end
      OP_MULTU: is_mult = 1'b1;
`ifdef MUL_ACC_EN
      OP_MADD:  begin is_mult = 1'b1; is_sgn = 1'b1; acc_d = ACC_ADD; end
      OP_MADDU: begin is_mult = 1'b1; acc_d = ACC_ADD; end
      OP_MSUB:  begin is_mult = 1'b1; is_sgn = 1'b1; acc_d = ACC_SUB; end
      OP_MSUBU: begin is_mult = 1'b1; acc_d = ACC_SUB; end
`endif
      default:  ;
    endcase
  end

  // Value written into {HI,LO} when the product arrives; wraps mod 2^64.
  always_comb begin
`ifdef MUL_ACC_EN
    case (acc_q)
      ACC_ADD: hilo_d = {hi_q, lo_q} + mul_result;
      ACC_SUB: hilo_d = {hi_q, lo_q} - mul_result;
      default: hilo_d = mul_result;
    endcase
`else
    hilo_d = mul_result;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      sign_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MUL_ACC_EN
      acc_q   <= ACC_NONE;
`endif
    end else if (flush) begin
      // Kill wins over everything, including a coincident mul_ready.
      state_q <= S_IDLE;
      start_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid && is_mult) begin
            a_q     <= rs_data;
            b_q     <= rt_data;
            sign_q  <= is_sgn;
`ifdef MUL_ACC_EN
            acc_q   <= acc_d;
`endif
            start_q <= 1'b1;
            state_q <= S_START;
          end else if (op_valid && op == OP_MTHI) begin
            hi_q <= rs_data;
          end else if (op_valid && op == OP_MTLO) begin
            lo_q <= rs_data;
          end
        end
        S_START: begin
          start_q <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_ready) begin
            {hi_q, lo_q} <= hilo_d;
            state_q      <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_o   = (state_q == S_IDLE && op_valid && is_mult && !flush) ||
                     state_q == S_START || state_q == S_WAIT;
  assign mul_start = start_q & ~flush;
  assign mul_sign  = sign_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

  always_comb begin
    hilo_rdata = '0;
    if (op_valid && (state_q == S_IDLE || state_q == S_DONE)) begin
      if (op == OP_MFHI)      hilo_rdata = hi_q;
      else if (op == OP_MFLO) hilo_rdata = lo_q;
    end
  end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl: behavioural 4-stage multiplier core, directed plan cases, then random op streams.
module tb_mul_hilo_ctrl;

`ifdef MUL_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, op_valid, flush;
  logic [3:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        stall_o, mul_start, mul_sign, mul_ready;
  logic [31:0] hilo_rdata, hi_o, lo_o, mul_a, mul_b;
  logic [63:0] mul_result;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_hilo;  // reference {HI,LO}

  always #5 clk = ~clk;

  mul_hilo_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .stall_o(stall_o), .hilo_rdata(hilo_rdata), .hi_o(hi_o), .lo_o(lo_o),
    .mul_start(mul_start), .mul_sign(mul_sign), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_ready(mul_ready)
  );

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic sg);
    logic [63:0] ea, eb;
    ea = sg ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sg ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Multiplier core: 4 stages, a new start discards anything in flight.
  logic [3:0]  cv;
  logic [63:0] cp0, cp1, cp2, cp3;
  always @(posedge clk) begin
    if (rst) cv <= 4'b0;
    else     cv <= mul_start ? 4'b0001 : {cv[2:0], 1'b0};
    cp0 <= prod(mul_a, mul_b, mul_sign);
    cp1 <= cp0;
    cp2 <= cp1;
    cp3 <= cp2;
  end
  assign mul_ready  = cv[3];
  assign mul_result = cp3;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1, returns at posedge+1 with op_valid low.
  task automatic idle_cycle();
    op_valid = 1'b0;
    op       = 4'($urandom_range(0, 15));
    flush    = 1'b0;
    #4;
    chk("idle_stall", {63'b0, stall_o}, 64'd0);
    chk("idle_rdata", {32'b0, hilo_rdata}, 64'd0);
    @(posedge clk); #1;
  endtask

  // Presents one instruction; fl = cycle at which flush is asserted, -1 for none.
  task automatic exec(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int fl);
    logic        mc, sg;
    int          acc;
    logic [63:0] p, nxt;
    mc = 1'b0; sg = 1'b0; acc = 0;
    case (o)
      4'd1: begin mc = 1'b1; sg = 1'b1; end
      4'd2: mc = 1'b1;
      4'd7: begin mc = ACC_EN; sg = 1'b1; acc = 1; end
      4'd8: begin mc = ACC_EN; acc = 1; end
      4'd9: begin mc = ACC_EN; sg = 1'b1; acc = 2; end
      4'd10: begin mc = ACC_EN; acc = 2; end
      default: ;
    endcase
    p   = prod(a, b, sg);
    nxt = (acc == 1) ? m_hilo + p : (acc == 2) ? m_hilo - p : p;

    op_valid = 1'b1; op = o; rs_data = a; rt_data = b; flush = (fl == 0);
    #4;
    chk("c0_hi", {32'b0, hi_o}, {32'b0, m_hilo[63:32]});
    chk("c0_lo", {32'b0, lo_o}, {32'b0, m_hilo[31:0]});
    chk("c0_stall", {63'b0, stall_o}, {63'b0, mc && fl != 0});
    chk("c0_rdata", {32'b0, hilo_rdata},
        (o == 4'd3) ? {32'b0, m_hilo[63:32]} : (o == 4'd4) ? {32'b0, m_hilo[31:0]} : 64'd0);
    @(posedge clk); #1;
    if (fl != 0) begin
      if (o == 4'd5) m_hilo[63:32] = a;
      if (o == 4'd6) m_hilo[31:0]  = a;
    end
    if (mc && fl != 0) begin
      for (int c = 1; c <= 6; c++) begin
        flush = (c == fl);
        #4;
        chk("stall", {63'b0, stall_o}, {63'b0, c <= 5});
        chk("start", {63'b0, mul_start}, {63'b0, c == 1 && fl != 1});
        if (c <= 5) begin
          chk("mul_a", {32'b0, mul_a}, {32'b0, a});
          chk("mul_b", {32'b0, mul_b}, {32'b0, b});
          chk("mul_sign", {63'b0, mul_sign}, {63'b0, sg});
        end else begin
          chk("res_hi", {32'b0, hi_o}, {32'b0, nxt[63:32]});
          chk("res_lo", {32'b0, lo_o}, {32'b0, nxt[31:0]});
          m_hilo = nxt;
        end
        @(posedge clk); #1;
        if (c == fl) break;
      end
    end
    op_valid = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = 4'd0; flush = 1'b0;
    rs_data = '0; rt_data = '0; m_hilo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", {32'b0, hi_o}, 64'd0);
    chk("rst_lo", {32'b0, lo_o}, 64'd0);
    chk("rst_stall", {63'b0, stall_o}, 64'd0);
    chk("rst_start", {63'b0, mul_start}, 64'd0);
    chk("rst_rdata", {32'b0, hilo_rdata}, 64'd0);
    chk("rst_sign", {63'b0, mul_sign}, 64'd0);
    chk("rst_a", {32'b0, mul_a}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    exec(4'd1, 32'hFFFFFFFE, 32'h00000003, -1);
    chk("plan_mult", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFA);
    exec(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    chk("plan_multu", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);

    exec(4'd5, 32'h12345678, 32'h0, -1);
    exec(4'd6, 32'h9ABCDEF0, 32'h0, -1);
    exec(4'd1, 32'h7, 32'h9, 3);
    exec(4'd4, 32'h0, 32'h0, -1);
    chk("plan_flush", {hi_o, lo_o}, 64'h12345678_9ABCDEF0);
    exec(4'd1, 32'h11111111, 32'h3, 5);   // flush coincides with mul_ready
    chk("flush_ready", {hi_o, lo_o}, 64'h12345678_9ABCDEF0);

    exec(4'd5, 32'h0, 32'h0, -1);
    exec(4'd6, 32'hFFFFFFFF, 32'h0, -1);
    exec(4'd8, 32'h1, 32'h1, -1);
    chk("plan_maddu", {hi_o, lo_o}, ACC_EN ? 64'h00000001_00000000 : 64'h00000000_FFFFFFFF);
    exec(4'd5, 32'h0, 32'h0, -1);
    exec(4'd6, 32'h0, 32'h0, -1);
    exec(4'd9, 32'h2, 32'h3, -1);
    chk("plan_msub", {hi_o, lo_o}, ACC_EN ? 64'hFFFFFFFF_FFFFFFFA : 64'h0);

    exec(4'd1, 32'h40000000, 32'h10, -1);
    exec(4'd3, 32'h0, 32'h0, -1);         // MFHI lands in cycle 7
    chk("b2b_hi", {32'b0, hi_o}, 64'h4);

    for (int i = 0; i < 250; i++) begin
      int fl;
      fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
      exec(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd(), fl);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
